// File: rtl/fft_agu_param.sv
// Address generation unit for an in-place radix-2 DIT FFT of 2**LOG2N points.
// Issues butterfly read/twiddle addresses and replays them as write-backs PIPE_LAT cycles later.
module fft_agu_param #(
  parameter int LOG2N    = 5,
  parameter int PIPE_LAT = 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     stall,
  output logic                     rd_valid,
  output logic [LOG2N-1:0]         rd_addr_a,
  output logic [LOG2N-1:0]         rd_addr_b,
  output logic [LOG2N-2:0]         tw_addr,
  output logic                     wr_en,
  output logic [LOG2N-1:0]         wr_addr_a,
  output logic [LOG2N-1:0]         wr_addr_b,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     busy,
  output logic                     done
);

  localparam int JW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Rotate-left within LOG2N bits: the upper half of {x,x}<<sh is the rotated word.
  function automatic logic [LOG2N-1:0] rotl(input logic [LOG2N-1:0] x, input logic [SW-1:0] sh);
    logic [2*LOG2N-1:0] d;
    d = {x, x} << sh;
    return d[2*LOG2N-1:LOG2N];
  endfunction

  function automatic logic [JW-1:0] twiddle(input logic [JW-1:0] j, input logic [SW-1:0] sh);
    return j & ~({JW{1'b1}} >> sh);
  endfunction

  state_t          state_r, state_s;
  logic [JW-1:0]   j_r, j_s;
  logic [SW-1:0]   s_r, s_s;
  logic [DW-1:0]   d_r, d_s;
  logic            done_s;

  logic            done_r;
  logic            busy_r;
  logic [LOG2N-1:0] rd_a_r;
  logic [LOG2N-1:0] rd_b_r;
  logic [JW-1:0]   tw_r;
  logic [SW-1:0]   stage_r;

  logic [PIPE_LAT-1:0]            pipe_v_r;
  logic [PIPE_LAT-1:0][LOG2N-1:0] pipe_a_r;
  logic [PIPE_LAT-1:0][LOG2N-1:0] pipe_b_r;

  // Sequencer state and butterfly/stage/drain counters.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      j_r     <= '0;
      s_r     <= '0;
      d_r     <= '0;
    end else begin
      state_r <= state_s;
      j_r     <= j_s;
      s_r     <= s_s;
      d_r     <= d_s;
    end
  end

  // Next-state logic; a stalled cycle leaves every counter untouched.
  always_comb begin
    state_s = state_r;
    j_s     = j_r;
    s_s     = s_r;
    d_s     = d_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          j_s     = '0;
          s_s     = '0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!stall) begin
          if (j_r == {JW{1'b1}}) begin
            state_s = DRAIN;
            j_s     = '0;
            d_s     = '0;
          end else begin
            j_s = j_r + JW'(1);
          end
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (d_r == DW'(PIPE_LAT - 1)) begin
            d_s = '0;
            j_s = '0;
            if (s_r == SW'(LOG2N - 1)) begin
              state_s = IDLE;
              s_s     = '0;
              done_s  = 1'b1;
            end else begin
              state_s = RUN;
              s_s     = s_r + SW'(1);
            end
          end else begin
            d_s = d_r + DW'(1);
          end
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        j_s     = '0;
        s_s     = '0;
        d_s     = '0;
      end
    endcase
  end

  // Registered outputs, decoded from the next counter values so they track j/s exactly.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      rd_a_r  <= '0;
      rd_b_r  <= '0;
      tw_r    <= '0;
      stage_r <= '0;
    end else begin
      done_r  <= done_s;
      busy_r  <= (state_s != IDLE);
      rd_a_r  <= rotl({j_s, 1'b0}, s_s);
      rd_b_r  <= rotl({j_s, 1'b1}, s_s);
      tw_r    <= twiddle(j_s, s_s);
      stage_r <= s_s;
    end
  end

  // Write-back delay line; frozen together with the sequencer during a stall.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pipe_v_r <= '0;
      pipe_a_r <= '0;
      pipe_b_r <= '0;
    end else if (!stall) begin
      pipe_v_r[0] <= (state_r == RUN);
      pipe_a_r[0] <= rd_a_r;
      pipe_b_r[0] <= rd_b_r;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_v_r[i] <= pipe_v_r[i-1];
        pipe_a_r[i] <= pipe_a_r[i-1];
        pipe_b_r[i] <= pipe_b_r[i-1];
      end
    end
  end

  assign rd_valid  = (state_r == RUN) && !stall;
  assign rd_addr_a = rd_a_r;
  assign rd_addr_b = rd_b_r;
  assign tw_addr   = tw_r;
  assign stage     = stage_r;
  assign wr_en     = pipe_v_r[PIPE_LAT-1] && !stall;
  assign wr_addr_a = pipe_a_r[PIPE_LAT-1];
  assign wr_addr_b = pipe_b_r[PIPE_LAT-1];
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_fft_agu_param.sv
// Bench for fft_agu_param: one 8-point/latency-2 instance under random stalls and
// start pulses, one 32-point/latency-1 instance run clean, both against a slot-index model.
module tb_fft_agu_param;

  localparam int L_A = 3;
  localparam int P_A = 2;
  localparam int L_B = 5;
  localparam int P_B = 1;
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;
  logic a_start, a_stall, a_rd_valid, a_wr_en, a_busy, a_done;
  logic [L_A-1:0] a_rd_addr_a, a_rd_addr_b, a_wr_addr_a, a_wr_addr_b;
  logic [L_A-2:0] a_tw_addr;
  logic [1:0]     a_stage;

  logic b_start, b_stall, b_rd_valid, b_wr_en, b_busy, b_done;
  logic [L_B-1:0] b_rd_addr_a, b_rd_addr_b, b_wr_addr_a, b_wr_addr_b;
  logic [L_B-2:0] b_tw_addr;
  logic [2:0]     b_stage;

  fft_agu_param #(.LOG2N(L_A), .PIPE_LAT(P_A)) dut_a (
    .clk(clk), .clr(clr), .start(a_start), .stall(a_stall),
    .rd_valid(a_rd_valid), .rd_addr_a(a_rd_addr_a), .rd_addr_b(a_rd_addr_b),
    .tw_addr(a_tw_addr), .wr_en(a_wr_en), .wr_addr_a(a_wr_addr_a),
    .wr_addr_b(a_wr_addr_b), .stage(a_stage), .busy(a_busy), .done(a_done)
  );

  fft_agu_param #(.LOG2N(L_B), .PIPE_LAT(P_B)) dut_b (
    .clk(clk), .clr(clr), .start(b_start), .stall(b_stall),
    .rd_valid(b_rd_valid), .rd_addr_a(b_rd_addr_a), .rd_addr_b(b_rd_addr_b),
    .tw_addr(b_tw_addr), .wr_en(b_wr_en), .wr_addr_a(b_wr_addr_a),
    .wr_addr_b(b_wr_addr_b), .stage(b_stage), .busy(b_busy), .done(b_done)
  );

  int checks = 0;
  int errors = 0;
  bit stall_tbl [LIMIT];
  int rd_cyc[$], wr_cyc[$], obs_a[$], obs_b[$], obs_tw[$], obs_st[$];

  int exp_rc [12] = '{0, 1, 2, 3, 6, 7, 8, 9, 12, 13, 14, 15};
  int exp_wc [12] = '{2, 3, 4, 5, 8, 9, 10, 11, 14, 15, 16, 17};
  int exp_ra [12] = '{0, 2, 4, 6, 0, 4, 1, 5, 0, 1, 2, 3};
  int exp_rb [12] = '{1, 3, 5, 7, 2, 6, 3, 7, 4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 2, 3};
  int exp_st [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

  function automatic int ref_rotl(int x, int s, int l);
    return ((x << s) | (x >> (l - s))) % (1 << l);
  endfunction

  function automatic int ref_tw(int j, int s, int l);
    int sh = l - 1 - s;
    return (j >> sh) << sh;
  endfunction

  // One transform on dut_a; u counts non-stalled cycles since C0, every event is a slot of u.
  task automatic run_a(input int stall_pct, input bit use_tbl, input bit hold,
                       input bit pulses, output int done_cyc);
    int half = (1 << L_A) / 2;
    int per = half + P_A;
    int total = L_A * per;
    int u = 0;
    int w, s, j;
    bit st, e_rd, e_wr, e_busy, e_done;
    done_cyc = -1;
    rd_cyc.delete(); wr_cyc.delete(); obs_a.delete(); obs_b.delete(); obs_tw.delete(); obs_st.delete();
    a_start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < LIMIT; c++) begin
      st = use_tbl ? stall_tbl[c] : ($urandom_range(0, 99) < stall_pct);
      a_stall = st;
      a_start = hold ? 1'b1 : ((pulses && u < total) ? 1'($urandom_range(0, 1)) : 1'b0);
      e_busy = (u < total);
      e_rd = !st && (u < total) && ((u % per) < half);
      w = u - P_A;
      e_wr = !st && (w >= 0) && (w < total) && ((w % per) < half);
      e_done = (u == total);
      @(negedge clk);
      checks += 4;
      if (a_rd_valid !== e_rd) begin errors++; $display("FAIL rd_valid c=%0d got=%b exp=%b", c, a_rd_valid, e_rd); end
      if (a_wr_en !== e_wr) begin errors++; $display("FAIL wr_en c=%0d got=%b exp=%b", c, a_wr_en, e_wr); end
      if (a_busy !== e_busy) begin errors++; $display("FAIL busy c=%0d got=%b exp=%b", c, a_busy, e_busy); end
      if (a_done !== e_done) begin errors++; $display("FAIL done c=%0d got=%b exp=%b", c, a_done, e_done); end
      if (e_rd) begin
        s = u / per; j = u % per;
        checks += 4;
        if (a_rd_addr_a !== ref_rotl(2*j, s, L_A)) begin errors++; $display("FAIL rd_addr_a c=%0d got=%0d exp=%0d", c, a_rd_addr_a, ref_rotl(2*j, s, L_A)); end
        if (a_rd_addr_b !== ref_rotl(2*j+1, s, L_A)) begin errors++; $display("FAIL rd_addr_b c=%0d got=%0d exp=%0d", c, a_rd_addr_b, ref_rotl(2*j+1, s, L_A)); end
        if (a_tw_addr !== ref_tw(j, s, L_A)) begin errors++; $display("FAIL tw_addr c=%0d got=%0d exp=%0d", c, a_tw_addr, ref_tw(j, s, L_A)); end
        if (a_stage !== s) begin errors++; $display("FAIL stage c=%0d got=%0d exp=%0d", c, a_stage, s); end
      end
      if (e_wr) begin
        s = w / per; j = w % per;
        checks += 2;
        if (a_wr_addr_a !== ref_rotl(2*j, s, L_A)) begin errors++; $display("FAIL wr_addr_a c=%0d got=%0d exp=%0d", c, a_wr_addr_a, ref_rotl(2*j, s, L_A)); end
        if (a_wr_addr_b !== ref_rotl(2*j+1, s, L_A)) begin errors++; $display("FAIL wr_addr_b c=%0d got=%0d exp=%0d", c, a_wr_addr_b, ref_rotl(2*j+1, s, L_A)); end
      end
      if (a_rd_valid === 1'b1) begin
        rd_cyc.push_back(c); obs_a.push_back(a_rd_addr_a); obs_b.push_back(a_rd_addr_b);
        obs_tw.push_back(a_tw_addr); obs_st.push_back(a_stage);
      end
      if (a_wr_en === 1'b1) wr_cyc.push_back(c);
      if (!st) u++;
      if (e_done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_cyc < 0) begin errors++; $display("FAIL run_timeout got=none exp=done within %0d cycles", LIMIT); end
    a_stall = 1'b0;
    if (!hold) a_start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; a_start = 1'b0; a_stall = 1'b0; b_start = 1'b0; b_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if ({a_rd_valid, a_wr_en, a_busy, a_done} !== 4'b0000) begin errors++; $display("FAIL reset_a_flags got=%b exp=0000", {a_rd_valid, a_wr_en, a_busy, a_done}); end
    if ({a_rd_addr_a, a_rd_addr_b, a_tw_addr, a_wr_addr_a, a_wr_addr_b, a_stage} !== '0) begin errors++; $display("FAIL reset_a_addr got=%h exp=0", {a_rd_addr_a, a_rd_addr_b, a_tw_addr, a_wr_addr_a, a_wr_addr_b, a_stage}); end
    if ({b_rd_valid, b_wr_en, b_busy, b_done, b_rd_addr_a, b_rd_addr_b, b_tw_addr, b_stage} !== '0) begin errors++; $display("FAIL reset_b got=%h exp=0", {b_rd_valid, b_wr_en, b_busy, b_done, b_rd_addr_a, b_rd_addr_b, b_tw_addr, b_stage}); end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_rd_valid, a_wr_en, a_busy, a_done} !== 4'b0000) begin errors++; $display("FAIL idle_after_reset got=%b exp=0000", {a_rd_valid, a_wr_en, a_busy, a_done}); end
    @(posedge clk); #1;
  endtask

  task automatic test_addresses();
    int dc;
    run_a(0, 1'b0, 1'b0, 1'b1, dc);
    checks += 3;
    if (dc !== 18) begin errors++; $display("FAIL done_cycle got=%0d exp=18", dc); end
    if (rd_cyc.size() !== 12) begin errors++; $display("FAIL read_count got=%0d exp=12", rd_cyc.size()); end
    if (wr_cyc.size() !== 12) begin errors++; $display("FAIL write_count got=%0d exp=12", wr_cyc.size()); end
    for (int i = 0; i < 12 && i < rd_cyc.size() && i < wr_cyc.size(); i++) begin
      checks += 6;
      if (rd_cyc[i] !== exp_rc[i]) begin errors++; $display("FAIL read_cycle i=%0d got=%0d exp=%0d", i, rd_cyc[i], exp_rc[i]); end
      if (wr_cyc[i] !== exp_wc[i]) begin errors++; $display("FAIL write_cycle i=%0d got=%0d exp=%0d", i, wr_cyc[i], exp_wc[i]); end
      if (obs_a[i] !== exp_ra[i]) begin errors++; $display("FAIL table_a i=%0d got=%0d exp=%0d", i, obs_a[i], exp_ra[i]); end
      if (obs_b[i] !== exp_rb[i]) begin errors++; $display("FAIL table_b i=%0d got=%0d exp=%0d", i, obs_b[i], exp_rb[i]); end
      if (obs_tw[i] !== exp_tw[i]) begin errors++; $display("FAIL table_tw i=%0d got=%0d exp=%0d", i, obs_tw[i], exp_tw[i]); end
      if (obs_st[i] !== exp_st[i]) begin errors++; $display("FAIL table_stage i=%0d got=%0d exp=%0d", i, obs_st[i], exp_st[i]); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_rd_valid, a_wr_en} !== 4'b0000) begin errors++; $display("FAIL idle_after_done got=%b exp=0000", {a_busy, a_done, a_rd_valid, a_wr_en}); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int dc;
    foreach (stall_tbl[i]) stall_tbl[i] = 1'b0;
    stall_tbl[1] = 1'b1; stall_tbl[2] = 1'b1; stall_tbl[3] = 1'b1;
    stall_tbl[7] = 1'b1; stall_tbl[8] = 1'b1;
    run_a(0, 1'b1, 1'b0, 1'b0, dc);
    checks += 2;
    if (dc !== 23) begin errors++; $display("FAIL stall_done_cycle got=%0d exp=23", dc); end
    if (obs_a.size() !== 12) begin errors++; $display("FAIL stall_read_count got=%0d exp=12", obs_a.size()); end
    for (int i = 0; i < 12 && i < obs_a.size(); i++) begin
      checks += 3;
      if (obs_a[i] !== exp_ra[i]) begin errors++; $display("FAIL stall_seq_a i=%0d got=%0d exp=%0d", i, obs_a[i], exp_ra[i]); end
      if (obs_b[i] !== exp_rb[i]) begin errors++; $display("FAIL stall_seq_b i=%0d got=%0d exp=%0d", i, obs_b[i], exp_rb[i]); end
      if (obs_tw[i] !== exp_tw[i]) begin errors++; $display("FAIL stall_seq_tw i=%0d got=%0d exp=%0d", i, obs_tw[i], exp_tw[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_stall();
    int dc;
    for (int r = 0; r < 6; r++) begin
      run_a(35, 1'b0, 1'b0, 1'b1, dc);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clr_mid();
    int dc;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_before_clr got=%b exp=1", a_busy); end
    clr = 1'b1;
    #1;
    checks += 2;
    if ({a_rd_valid, a_wr_en, a_busy, a_done} !== 4'b0000) begin errors++; $display("FAIL clr_flags got=%b exp=0000", {a_rd_valid, a_wr_en, a_busy, a_done}); end
    if ({a_rd_addr_a, a_rd_addr_b, a_tw_addr, a_wr_addr_a, a_wr_addr_b, a_stage} !== '0) begin errors++; $display("FAIL clr_addr got=%h exp=0", {a_rd_addr_a, a_rd_addr_b, a_tw_addr, a_wr_addr_a, a_wr_addr_b, a_stage}); end
    @(posedge clk); #1;
    clr = 1'b0;
    for (int c = 0; c < P_A + 3; c++) begin
      @(negedge clk);
      checks++;
      if ({a_rd_valid, a_wr_en, a_busy} !== 3'b000) begin errors++; $display("FAIL after_clr c=%0d got=%b exp=000", c, {a_rd_valid, a_wr_en, a_busy}); end
      @(posedge clk); #1;
    end
    run_a(0, 1'b0, 1'b0, 1'b0, dc);
    checks++;
    if (dc !== 18) begin errors++; $display("FAIL rerun_done_cycle got=%0d exp=18", dc); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int dc;
    run_a(0, 1'b0, 1'b1, 1'b0, dc);
    checks++;
    if (dc !== 18) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=18", dc); end
    @(posedge clk); #1;
    a_start = 1'b0;
    @(negedge clk);
    checks += 3;
    if ({a_rd_valid, a_busy, a_done} !== 3'b110) begin errors++; $display("FAIL b2b_c19_flags got=%b exp=110", {a_rd_valid, a_busy, a_done}); end
    if ({a_rd_addr_a, a_rd_addr_b} !== {3'd0, 3'd1}) begin errors++; $display("FAIL b2b_c19_addr got=%0d,%0d exp=0,1", a_rd_addr_a, a_rd_addr_b); end
    if (a_stage !== 2'd0) begin errors++; $display("FAIL b2b_c19_stage got=%0d exp=0", a_stage); end
    #1;
    clr = 1'b1;
    #2;
    clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_large();
    int half = (1 << L_B) / 2;
    int per = half + P_B;
    int total = L_B * per;
    int nrd = 0;
    int dc = -1;
    int s, j, w;
    bit e_rd, e_wr;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int c = 0; c < LIMIT; c++) begin
      e_rd = (c < total) && ((c % per) < half);
      w = c - P_B;
      e_wr = (w >= 0) && (w < total) && ((w % per) < half);
      @(negedge clk);
      checks += 4;
      if (b_rd_valid !== e_rd) begin errors++; $display("FAIL big_rd_valid c=%0d got=%b exp=%b", c, b_rd_valid, e_rd); end
      if (b_wr_en !== e_wr) begin errors++; $display("FAIL big_wr_en c=%0d got=%b exp=%b", c, b_wr_en, e_wr); end
      if (b_busy !== (c < total)) begin errors++; $display("FAIL big_busy c=%0d got=%b exp=%b", c, b_busy, c < total); end
      if (b_done !== (c == total)) begin errors++; $display("FAIL big_done c=%0d got=%b exp=%b", c, b_done, c == total); end
      if (e_rd) begin
        s = c / per; j = c % per; nrd++;
        checks += 3;
        if ({b_rd_addr_a, b_rd_addr_b} !== {5'(ref_rotl(2*j, s, L_B)), 5'(ref_rotl(2*j+1, s, L_B))}) begin errors++; $display("FAIL big_rd_addr c=%0d got=%0d,%0d exp=%0d,%0d", c, b_rd_addr_a, b_rd_addr_b, ref_rotl(2*j, s, L_B), ref_rotl(2*j+1, s, L_B)); end
        if (b_stage !== s) begin errors++; $display("FAIL big_stage c=%0d got=%0d exp=%0d", c, b_stage, s); end
        if (b_tw_addr !== ((s == L_B - 1) ? j : ref_tw(j, s, L_B))) begin errors++; $display("FAIL big_tw c=%0d got=%0d exp=%0d", c, b_tw_addr, ref_tw(j, s, L_B)); end
      end
      if (e_wr) begin
        s = w / per; j = w % per;
        checks++;
        if ({b_wr_addr_a, b_wr_addr_b} !== {5'(ref_rotl(2*j, s, L_B)), 5'(ref_rotl(2*j+1, s, L_B))}) begin errors++; $display("FAIL big_wr_addr c=%0d got=%0d,%0d", c, b_wr_addr_a, b_wr_addr_b); end
      end
      if (c == total) begin
        dc = c;
        break;
      end
      @(posedge clk); #1;
    end
    checks += 2;
    if (dc !== 85) begin errors++; $display("FAIL big_done_cycle got=%0d exp=85", dc); end
    if (nrd !== 80) begin errors++; $display("FAIL big_read_count got=%0d exp=80", nrd); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_addresses();
    test_stall();
    test_random_stall();
    test_clr_mid();
    test_back_to_back();
    test_large();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_agu_param.md
# fft_agu_param

Parametrised address generation unit for an in-place radix-2 DIT FFT of N = 2^LOG2N points. Sequences LOG2N stages of N/2 butterflies. For each butterfly it issues the operand-A/B read addresses and the twiddle address, then the matching write-back addresses PIPE_LAT cycles later. It inserts a drain gap between stages, supports a stall input, and sits between the FFT controller and the data/twiddle memories.

## Interface
- LOG2N, default 5: log2 of FFT size; legal range 2..10.
- PIPE_LAT, default 2: read-to-write latency of memory plus butterfly, in cycles; legal range 1..8.
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset; asynchronous, active-high.
- start  in  1  level; sampled only in IDLE, where high launches a transform.
- stall  in  1  freezes all counters and the write pipe while high.
- rd_valid  out  1  read addresses valid this cycle.
- rd_addr_a  out  LOG2N  operand-A read address.
- rd_addr_b  out  LOG2N  operand-B read address.
- tw_addr  out  LOG2N-1  twiddle index k, meaning W_N^k.
- wr_en  out  1  write-back strobe.
- wr_addr_a  out  LOG2N  operand-A write address.
- wr_addr_b  out  LOG2N  operand-B write address.
- stage  out  ceil(log2(LOG2N))  current stage s.
- busy  out  1  transform in progress.
- done  out  1  one-cycle pulse when the final write has completed.

## Operation
- FSM states are IDLE, RUN and DRAIN.
- IDLE -> RUN when start is high; j = 0, s = 0.
- RUN: each non-stalled cycle issues butterfly j, then j++. After j = N/2-1 the FSM goes to DRAIN with drain counter = 0.
- DRAIN: each non-stalled cycle increments the drain counter. When it reaches PIPE_LAT-1:
  - if s < LOG2N-1: s++, j = 0, back to RUN;
  - otherwise go to IDLE and pulse done.
- Address rule: rd_addr_a = rotl(2j, s) and rd_addr_b = rotl(2j+1, s), both LOG2N bits wide. rotl is a rotate-left by s within LOG2N bits.
- Twiddle rule: tw_addr = j with its low (LOG2N-1-s) bits cleared, i.e. the top s bits of the (LOG2N-1)-bit j are kept.
  - Stage 0 always gives 0.
  - The last stage gives j.
- Write pipe: a PIPE_LAT-deep shift register of {valid, addr_a, addr_b}. It advances only when stall is low.
  - wr_en = pipe output valid AND NOT stall.
  - wr_addr_a/b = pipe output addresses.
- rd_valid = (state == RUN) AND NOT stall. Address outputs hold their values while stalled.
- stage and tw_addr are meaningful only while rd_valid is high.
- busy = (state != IDLE).
- start while busy is ignored. start held high across done launches a new transform on the cycle after done.
- Reset, including mid-transform: all registers clear immediately. The FSM goes to IDLE, the write pipe is emptied, and no pending writes are emitted.

## Timing
- Reset values:
  - rd_valid, wr_en, busy, done = 0;
  - all addresses = 0;
  - stage = 0.
- The start edge at E0 makes cycle C0 the first RUN cycle, with rd_valid high in C0.
- A read in cycle t is followed by its write in cycle t+PIPE_LAT, counting non-stalled cycles only.
- Each stage takes N/2 read cycles plus PIPE_LAT drain cycles. The last write of a stage precedes the first read of the next stage, so there are no read-after-write hazards.
- Unstalled transform: busy high for LOG2N*(N/2+PIPE_LAT) cycles; done high in the first cycle after that, with busy already low.
- Each stall cycle extends every later event by exactly one cycle.
- rd_valid and wr_en have a combinational path from stall. All other outputs are registered or decoded from state.

## Test plan
- LOG2N=3, PIPE_LAT=2, start pulse -> reads and twiddles per stage:
  - stage 0 pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0;
  - stage 1 pairs (0,2)(4,6)(1,3)(5,7), tw 0,0,2,2;
  - stage 2 pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
- Same configuration, cycle check:
  - reads in C0–C3, C6–C9 and C12–C15;
  - wr_en in C2–C5, C8–C11 and C14–C17 with the matching addresses;
  - busy high C0–C17; done only in C18.
- Stall high at C1 for 3 cycles, then again during a DRAIN cycle:
  - no rd_valid or wr_en while stalled;
  - address sequence unchanged;
  - done at C23.
- clr asserted at C7 mid-transform -> outputs at their reset values immediately and no further wr_en; a new start runs the full sequence from stage 0.
- start held high continuously -> back-to-back transforms with done in C18 and rd_valid again in C19; start pulses while busy have no effect.
- LOG2N=5, PIPE_LAT=1 -> 5 stages of 16 reads each; done in cycle 85; stage-4 tw_addr = j for j = 0..15.
